conv3x3_mac: RTL and testbench



---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_weight_regs.sv | 42 ++++
 rtl/conv3x3_mac.sv | 184 ++++++++++++++++++
 tb/tb_conv3x3_mac.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the conv3x3 MAC stage
// Purpose: FSM state encoding, default geometry of the MAC datapath and
//          the signed 16-bit saturation bounds applied to the result.
// Ports:   none (package)
package conv_pkg;

  localparam int NUM_TAPS  = 9;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;
  localparam int ACC_W     = 36;

  localparam int SAT_MAX   = 32767;
  localparam int SAT_MIN   = -32768;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/conv_weight_regs.sv
// rtl/conv_weight_regs.sv - NUM_TAPS x DATA_W signed weight register file
// Purpose: holds the Q8.8 kernel weights; writes are only accepted while
//          the MAC is idle and the index is inside the kernel.
// Ports:   i_clk, i_rst    clock, async active-high reset (clears weights)
//          i_wen, i_busy   write enable, MAC busy (blocks writes)
//          i_waddr/i_wdata write index and weight
//          i_raddr/o_rdata combinational read, indexed by the tap counter
module conv_weight_regs #(
  parameter int NUM_TAPS = 9,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wen,
  input  logic              i_busy,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(NUM_TAPS);

  logic [DATA_W-1:0] r_w [NUM_TAPS];
  logic              w_wr;

  assign w_wr = i_wen && !i_busy && (i_waddr < DEPTH);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_w[i] <= '0;
      end
    end else if (w_wr) begin
      r_w[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = (i_raddr < DEPTH) ? r_w[i_raddr] : '0;

endmodule

// File: rtl/conv3x3_mac.sv
// rtl/conv3x3_mac.sv - sequential 3x3 multiply-accumulate with saturation/ReLU
// Purpose: on start, walks image RAM addresses 0..NUM_TAPS-1, multiplies each
//          pixel by its stored weight, accumulates, rescales by FRAC_BITS,
//          saturates to 16 bits, optionally applies ReLU and pulses done.
// Ports:   clk, rst              clock, async active-high reset
//          start, relu_en        launch a window; ReLU select latched at launch
//          img_raddr, img_rdata  image RAM address (registered) / async data
//          w_wen/w_waddr/w_wdata weight write port (ignored while busy)
//          busy                  state != IDLE
//          done                  one-cycle pulse, result/ovf valid
//          result, ovf           signed Q8.8 result and saturation flag, held
module conv3x3_mac #(
  parameter int NUM_TAPS  = conv_pkg::NUM_TAPS,
  parameter int ADDR_W    = conv_pkg::ADDR_W,
  parameter int DATA_W    = conv_pkg::DATA_W,
  parameter int FRAC_BITS = conv_pkg::FRAC_BITS,
  parameter int ACC_W     = conv_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              relu_en,
  output logic [ADDR_W-1:0] img_raddr,
  input  logic [DATA_W-1:0] img_rdata,
  input  logic              w_wen,
  input  logic [ADDR_W-1:0] w_waddr,
  input  logic [DATA_W-1:0] w_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  import conv_pkg::*;

  localparam int PW = 2 * DATA_W;
  localparam int SW = ACC_W - FRAC_BITS;
  localparam logic [ADDR_W-1:0]    LAST_TAP = ADDR_W'(NUM_TAPS - 1);
  localparam logic signed [SW-1:0] S_MAX    = SW'(SAT_MAX);
  localparam logic signed [SW-1:0] S_MIN    = SW'(SAT_MIN);
  localparam logic [DATA_W-1:0]    RES_MAX  = DATA_W'(SAT_MAX);
  localparam logic [DATA_W-1:0]    RES_MIN  = DATA_W'(SAT_MIN);

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_W-1:0]       r_tap;
  logic signed [PW-1:0]    r_prod;
  logic                    r_prod_vld;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_relu;
  logic [DATA_W-1:0]       r_result;
  logic                    r_ovf;
  logic                    r_done;

  logic                    w_busy;
  logic                    w_run;
  logic                    w_finish;
  logic                    w_launch;
  logic                    w_last;
  logic [DATA_W-1:0]       w_weight;
  logic signed [PW-1:0]    w_pix_ext;
  logic signed [PW-1:0]    w_wgt_ext;
  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [SW-1:0]    w_shift;
  logic [DATA_W-1:0]       w_sat;
  logic                    w_ovf;
  logic [DATA_W-1:0]       w_result;

  conv_weight_regs #(
    .NUM_TAPS (NUM_TAPS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_weights (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_wen   (w_wen),
    .i_busy  (w_busy),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (r_tap),
    .o_rdata (w_weight)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_RUN;
      ST_RUN:    if (w_last) w_next = ST_DRAIN;
      ST_DRAIN:  w_next = ST_FINISH;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_busy   = (r_state != ST_IDLE);
    w_run    = (r_state == ST_RUN);
    w_finish = (r_state == ST_FINISH);
    w_launch = (r_state == ST_IDLE) && start;
  end

  assign w_last = (r_tap == LAST_TAP);

  // Operands are sign-extended to the product width so the multiply is done
  // at full width; the low PW bits are the exact signed product.
  assign w_pix_ext  = {{DATA_W{img_rdata[DATA_W-1]}}, img_rdata};
  assign w_wgt_ext  = {{DATA_W{w_weight[DATA_W-1]}}, w_weight};
  assign w_prod     = w_pix_ext * w_wgt_ext;
  assign w_prod_ext = {{(ACC_W-PW){r_prod[PW-1]}}, r_prod};

  // Dropping the low FRAC_BITS bits of a two's complement value is the
  // arithmetic shift with truncation toward -inf.
  assign w_shift = r_acc[ACC_W-1:FRAC_BITS];

  always_comb begin
    w_sat = w_shift[DATA_W-1:0];
    w_ovf = 1'b0;
    if (w_shift > S_MAX) begin
      w_sat = RES_MAX;
      w_ovf = 1'b1;
    end else if (w_shift < S_MIN) begin
      w_sat = RES_MIN;
      w_ovf = 1'b1;
    end
    w_result = (r_relu && w_sat[DATA_W-1]) ? '0 : w_sat;
  end

  // Datapath: the product register lags the tap counter by one cycle, so the
  // last product is absorbed into the accumulator during DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tap      <= '0;
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_acc      <= '0;
      r_relu     <= 1'b0;
      r_result   <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_prod_vld <= w_run;
      if (w_run) begin
        r_prod <= w_prod;
      end
      if (w_launch) begin
        r_tap  <= '0;
        r_acc  <= '0;
        r_relu <= relu_en;
      end else begin
        if (w_run) begin
          r_tap <= w_last ? '0 : r_tap + 1'b1;
        end
        if (r_prod_vld) begin
          r_acc <= r_acc + w_prod_ext;
        end
      end
      if (w_finish) begin
        r_done   <= 1'b1;
        r_result <= w_result;
        r_ovf    <= w_ovf;
      end
    end
  end

  assign img_raddr = r_tap;
  assign busy      = w_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_conv3x3_mac.sv
// tb/tb_conv3x3_mac.sv - self-checking bench for conv3x3_mac
module tb_conv3x3_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        relu_en;
  logic [3:0]  img_raddr;
  logic [15:0] img_rdata;
  logic        w_wen;
  logic [3:0]  w_waddr;
  logic [15:0] w_wdata;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovf;

  logic [15:0] tb_img [9];
  logic [15:0] tb_w   [9];
  logic [3:0]  ra     [9];
  bit          busy_bad;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign img_rdata = (img_raddr < 4'd9) ? tb_img[img_raddr] : 16'h0000;

  conv3x3_mac dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .relu_en   (relu_en),
    .img_raddr (img_raddr),
    .img_rdata (img_rdata),
    .w_wen     (w_wen),
    .w_waddr   (w_waddr),
    .w_wdata   (w_wdata),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .ovf       (ovf)
  );

  typedef struct {
    logic [15:0] img_v;
    logic [15:0] w_v;
    bit          relu;
    logic [15:0] exp_res;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer dot product, floor division by 256, clamp, ReLU.
  function automatic void model(input bit relu, output logic [15:0] r, output bit o);
    longint acc = 0;
    longint s;
    for (int i = 0; i < 9; i++) begin
      acc += longint'($signed(tb_img[i])) * longint'($signed(tb_w[i]));
    end
    s = acc >>> 8;
    o = 1'b0;
    if (s > 32767) begin
      s = 32767; o = 1'b1;
    end else if (s < -32768) begin
      s = -32768; o = 1'b1;
    end
    if (relu && s < 0) s = 0;
    r = 16'(s);
  endfunction

  task automatic fill_img(input logic [15:0] v);
    for (int i = 0; i < 9; i++) tb_img[i] = v;
  endtask

  task automatic load_weights();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      w_wen = 1'b1; w_waddr = 4'(i); w_wdata = tb_w[i];
    end
    @(negedge clk);
    w_wen = 1'b0;
  endtask

  task automatic load_fill(input logic [15:0] v);
    for (int i = 0; i < 9; i++) tb_w[i] = v;
    load_weights();
  endtask

  // Called in the cycle where start should be seen; returns at E0 + #1.
  task automatic launch_now();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ra[0] = img_raddr;
  endtask

  task automatic launch();
    @(negedge clk);
    launch_now();
  endtask

  // Counts edges after E0 until done; inj > 0 pokes start and a weight write
  // into the middle of the window.
  task automatic wait_done(input int inj, output int lat);
    lat = -1;
    busy_bad = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (n == inj) begin
        start = 1'b1; w_wen = 1'b1; w_waddr = 4'd0; w_wdata = 16'h7fff;
      end else if (n == inj + 1) begin
        start = 1'b0; w_wen = 1'b0;
      end
      if (n <= 8) ra[n] = img_raddr;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_bad = 1'b1;
    end
    start = 1'b0; w_wen = 1'b0;
  endtask

  task automatic finish_check(input string nm, input int lat,
                              input logic [15:0] er, input bit eo);
    check({nm, "_latency"}, lat, 11);
    check({nm, "_result"}, result, er);
    check({nm, "_ovf"}, ovf, eo);
    check({nm, "_busy_in_done"}, busy, 0);
    check({nm, "_busy_during"}, busy_bad, 0);
  endtask

  initial begin
    int          lat;
    logic [15:0] er;
    bit          eo;
    bit          seen;

    rst = 1'b1; start = 1'b0; relu_en = 1'b0;
    w_wen = 1'b0; w_waddr = '0; w_wdata = '0;
    fill_img(16'h0000);
    for (int i = 0; i < 9; i++) tb_w[i] = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_ovf", ovf, 0);
    check("reset_raddr", img_raddr, 0);
    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{16'h0001, 16'h0100, 1'b0, 16'h0009, 1'b0};
    vecs[1] = '{16'h0100, 16'hff00, 1'b0, 16'hf700, 1'b0};
    vecs[2] = '{16'h0100, 16'hff00, 1'b1, 16'h0000, 1'b0};
    vecs[3] = '{16'h7fff, 16'h7fff, 1'b0, 16'h7fff, 1'b1};
    vecs[4] = '{16'h7fff, 16'h8000, 1'b0, 16'h8000, 1'b1};

    for (int v = 0; v < 5; v++) begin
      fill_img(vecs[v].img_v);
      load_fill(vecs[v].w_v);
      relu_en = vecs[v].relu;
      launch();
      relu_en = ~vecs[v].relu;   // must not matter once latched
      wait_done(-1, lat);
      finish_check($sformatf("vec%0d", v), lat, vecs[v].exp_res, vecs[v].exp_ovf);
      if (v == 0) begin
        for (int i = 0; i < 9; i++) check($sformatf("raddr_%0d", i), ra[i], i);
      end
    end

    // negative saturation with ReLU: result forced to 0, ovf stays set
    fill_img(16'h7fff);
    load_fill(16'h8000);
    relu_en = 1'b1;
    launch();
    relu_en = 1'b0;
    wait_done(-1, lat);
    finish_check("sat_relu", lat, 16'h0000, 1'b1);

    for (int it = 0; it < 20; it++) begin
      bit rl;
      for (int i = 0; i < 9; i++) begin
        if (it % 2 == 0) begin
          tb_img[i] = 16'($urandom_range(0, 4095)) - 16'd2048;
          tb_w[i]   = 16'($urandom_range(0, 1023)) - 16'd512;
        end else begin
          tb_img[i] = 16'($urandom);
          tb_w[i]   = 16'($urandom);
        end
      end
      rl = 1'($urandom_range(0, 1));
      load_weights();
      model(rl, er, eo);
      relu_en = rl;
      launch();
      wait_done(-1, lat);
      check($sformatf("rand%0d_result", it), result, er);
      check($sformatf("rand%0d_ovf", it), ovf, eo);
    end

    // start and weight write during RUN are ignored; then back-to-back window
    fill_img(16'h0001);
    load_fill(16'h0100);
    relu_en = 1'b0;
    launch();
    wait_done(3, lat);
    finish_check("midrun", lat, 16'h0009, 1'b0);
    launch_now();
    wait_done(-1, lat);
    finish_check("b2b", lat, 16'h0009, 1'b0);

    // reset at RUN cycle 5 aborts the window and clears the weights
    launch();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_raddr", img_raddr, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    for (int i = 0; i < 9; i++) tb_w[i] = 16'h0000;
    model(1'b0, er, eo);
    launch();
    wait_done(-1, lat);
    finish_check("zero_weights", lat, er, eo);
    load_fill(16'h0100);
    launch();
    wait_done(-1, lat);
    finish_check("reload", lat, 16'h0009, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
